reservation_station: RTL

//  Issue queue directly downstream of Rename. Accepts renamed ops (physical rd, source tags, ready bits and values).

---
 rtl/rs_pkg.sv | 32 +++
 rtl/rs_operand_capture.sv | 28 ++
 rtl/reservation_station.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared types and default widths for the reservation station.
//   rs_src_t   : one source operand {tag, ready, value}
//   rs_entry_t : one queue slot {valid, op, rd, src1, src2}
//   wakeup_t   : one completion broadcast {active, tag, value}
package rs_pkg;

    localparam int RS_TAG_W      = 6;
    localparam int RS_DATA_W     = 32;
    localparam int RS_OP_W       = 16;
    localparam int RS_WAKE_PORTS = 4;

    typedef struct packed {
        logic [RS_TAG_W-1:0]  tag;
        logic                 ready;
        logic [RS_DATA_W-1:0] value;
    } rs_src_t;

    typedef struct packed {
        logic                valid;
        logic [RS_OP_W-1:0]  op;
        logic [RS_TAG_W-1:0] rd;
        rs_src_t             src1;
        rs_src_t             src2;
    } rs_entry_t;

    typedef struct packed {
        logic                 active;
        logic [RS_TAG_W-1:0]  tag;
        logic [RS_DATA_W-1:0] value;
    } wakeup_t;

endpackage

// File: rtl/rs_operand_capture.sv
// Wakeup snoop for a single source operand.
//   src_i    : current source state (tag/ready/value)
//   wakeup_i : the four completion broadcasts
//   src_o    : source state after this cycle's broadcasts
// A source that is already ready passes through untouched. When several
// ports match, the lowest-numbered port supplies the value.
module rs_operand_capture
    import rs_pkg::*;
(
    input  rs_src_t                     src_i,
    input  wakeup_t [RS_WAKE_PORTS-1:0] wakeup_i,
    output rs_src_t                     src_o
);

    always_comb begin
        src_o = src_i;
        if (!src_i.ready) begin
            // Descending scan so the lowest matching port is applied last.
            for (int n = RS_WAKE_PORTS - 1; n >= 0; n--) begin
                if (wakeup_i[n].active && (wakeup_i[n].tag == src_i.tag)) begin
                    src_o.ready = 1'b1;
                    src_o.value = wakeup_i[n].value;
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Issue queue between Rename and Execute.
// Inputs : clk, reset (async, active-low), flush, dispatch_* (op from
//          Rename, valid/ready), wakeup_0..3_* (completion broadcasts),
//          issue_ready (execute accepts).
// Outputs: dispatch_ready, issue_valid + issue_op/rd/rs1_value/rs2_value
//          (zero when not valid), occupancy (valid entry count).
// Optional feature: define RS_OLDEST_FIRST_EN to select the oldest eligible
// entry (age matrix); otherwise the lowest-index eligible entry issues.
module reservation_station
    import rs_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = RS_TAG_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int OP_W    = RS_OP_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  logic [OP_W-1:0]              dispatch_op,
    input  logic [TAG_W-1:0]             dispatch_rd,
    input  logic [TAG_W-1:0]             dispatch_rs1_tag,
    input  logic                         dispatch_rs1_ready,
    input  logic [DATA_W-1:0]            dispatch_rs1_value,
    input  logic [TAG_W-1:0]             dispatch_rs2_tag,
    input  logic                         dispatch_rs2_ready,
    input  logic [DATA_W-1:0]            dispatch_rs2_value,
    input  logic                         wakeup_0_active,
    input  logic [TAG_W-1:0]             wakeup_0_tag,
    input  logic [DATA_W-1:0]            wakeup_0_value,
    input  logic                         wakeup_1_active,
    input  logic [TAG_W-1:0]             wakeup_1_tag,
    input  logic [DATA_W-1:0]            wakeup_1_value,
    input  logic                         wakeup_2_active,
    input  logic [TAG_W-1:0]             wakeup_2_tag,
    input  logic [DATA_W-1:0]            wakeup_2_value,
    input  logic                         wakeup_3_active,
    input  logic [TAG_W-1:0]             wakeup_3_tag,
    input  logic [DATA_W-1:0]            wakeup_3_value,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [OP_W-1:0]              issue_op,
    output logic [TAG_W-1:0]             issue_rd,
    output logic [DATA_W-1:0]            issue_rs1_value,
    output logic [DATA_W-1:0]            issue_rs2_value,
    output logic [$clog2(ENTRIES+1)-1:0] occupancy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = $clog2(ENTRIES + 1);

    wakeup_t [RS_WAKE_PORTS-1:0] wk;
    assign wk[0] = {wakeup_0_active, wakeup_0_tag, wakeup_0_value};
    assign wk[1] = {wakeup_1_active, wakeup_1_tag, wakeup_1_value};
    assign wk[2] = {wakeup_2_active, wakeup_2_tag, wakeup_2_value};
    assign wk[3] = {wakeup_3_active, wakeup_3_tag, wakeup_3_value};

    rs_entry_t           entries_q [ENTRIES];
    rs_entry_t           entries_d [ENTRIES];
    rs_src_t             woke1 [ENTRIES];
    rs_src_t             woke2 [ENTRIES];
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                hold_q, hold_d;
    logic [IDX_W-1:0]    hold_idx_q, hold_idx_d;
    logic [ENTRIES-1:0]  elig;
    logic                free_found, pick_found;
    logic [IDX_W-1:0]    free_idx, pick_idx, sel_idx;
    logic                dispatch_fire, issue_fire;
    rs_src_t             disp_src1_in, disp_src2_in, disp_src1, disp_src2;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cap
        rs_operand_capture u_cap1 (.src_i(entries_q[g].src1), .wakeup_i(wk), .src_o(woke1[g]));
        rs_operand_capture u_cap2 (.src_i(entries_q[g].src2), .wakeup_i(wk), .src_o(woke2[g]));
        assign elig[g] = entries_q[g].valid && entries_q[g].src1.ready && entries_q[g].src2.ready;
    end

    // Dispatch path snoops the same broadcasts so an op racing its producer is not missed.
    assign disp_src1_in = {dispatch_rs1_tag, dispatch_rs1_ready, dispatch_rs1_value};
    assign disp_src2_in = {dispatch_rs2_tag, dispatch_rs2_ready, dispatch_rs2_value};
    rs_operand_capture u_disp_cap1 (.src_i(disp_src1_in), .wakeup_i(wk), .src_o(disp_src1));
    rs_operand_capture u_disp_cap2 (.src_i(disp_src2_in), .wakeup_i(wk), .src_o(disp_src2));

    assign dispatch_ready = (occ_q < OCC_W'(ENTRIES));
    assign occupancy      = occ_q;
    assign dispatch_fire  = dispatch_valid && dispatch_ready;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!entries_q[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // age_q[r][c] = 1 means entry r was dispatched before entry c.
    logic [ENTRIES-1:0] age_q [ENTRIES];
    logic [ENTRIES-1:0] age_d [ENTRIES];

    always_comb begin
        logic older;
        pick_found = 1'b0;
        pick_idx   = '0;
        older      = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            older = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (elig[j] && age_q[j][i]) older = 1'b1;
            end
            if (elig[i] && !older && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        age_d = age_q;
        if (issue_fire) begin
            age_d[sel_idx] = '0;
            for (int j = 0; j < ENTRIES; j++) age_d[j][sel_idx] = 1'b0;
        end
        if (dispatch_fire) begin
            // New entry is younger than every survivor; the slot issuing now is not a survivor.
            age_d[free_idx] = '0;
            for (int j = 0; j < ENTRIES; j++) begin
                age_d[j][free_idx] = entries_q[j].valid && !(issue_fire && (IDX_W'(j) == sel_idx));
            end
        end
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) age_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (elig[i] && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end
`endif

    // A stalled selection is pinned so the payload cannot change under the consumer.
    assign sel_idx     = hold_q ? hold_idx_q : pick_idx;
    assign issue_valid = hold_q || pick_found;
    assign issue_fire  = issue_valid && issue_ready;

    always_comb begin
        issue_op        = '0;
        issue_rd        = '0;
        issue_rs1_value = '0;
        issue_rs2_value = '0;
        if (issue_valid) begin
            issue_op        = entries_q[sel_idx].op;
            issue_rd        = entries_q[sel_idx].rd;
            issue_rs1_value = entries_q[sel_idx].src1.value;
            issue_rs2_value = entries_q[sel_idx].src2.value;
        end
    end

    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries_q[i].valid) begin
                entries_d[i].src1 = woke1[i];
                entries_d[i].src2 = woke2[i];
            end
        end
        if (issue_fire) entries_d[sel_idx].valid = 1'b0;
        if (dispatch_fire) begin
            entries_d[free_idx] = {1'b1, dispatch_op, dispatch_rd, disp_src1, disp_src2};
        end
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
        end

        occ_d      = flush ? '0 : occ_q + OCC_W'(dispatch_fire) - OCC_W'(issue_fire);
        hold_d     = issue_valid && !issue_ready && !flush;
        hold_idx_d = sel_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
            occ_q      <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            entries_q  <= entries_d;
            occ_q      <= occ_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    // Two active broadcasts carrying the same tag indicate a producer bug upstream.
    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < RS_WAKE_PORTS; a++) begin
                for (int b = a + 1; b < RS_WAKE_PORTS; b++) begin
                    assert (!(wk[a].active && wk[b].active && (wk[a].tag == wk[b].tag)));
                end
            end
        end
    end

endmodule
